// File: rtl/filter_pkg.sv
// Shared definitions for the pre-filter writer and post-filter reader ping-pong pair.
package filter_pkg;

  localparam int LEN_W = 13;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic bank;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/post_filter_reader_tag_delay_line.sv
// RD_LAT-stage shift register aligning read tags with FIFO output data.
module tag_delay_line #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DW     = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] pipe_q [RD_LAT];
  logic [DW-1:0] pipe_d [RD_LAT];

  always_comb begin
    pipe_d[0] = din;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[RD_LAT-1];

endmodule

// File: rtl/post_filter_reader.sv
// Ping-pong FIFO pair reader: drains pair A then pair B in packer_len-word blocks,
// tagging returned data with valid/bank/first/last.
module post_filter_reader #(
  parameter int LEN_W  = filter_pkg::LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             ce,
  input  logic             reset,
  input  logic [LEN_W-1:0] packer_len,
  input  logic             enable,
  input  logic             dst_rdy,
  input  logic             fifo_empty1,
  input  logic             fifo_empty2,
  input  logic             fifo_empty3,
  input  logic             fifo_empty4,
  output logic             fifo_rd1,
  output logic             fifo_rd2,
  output logic             fifo_rd3,
  output logic             fifo_rd4,
  output logic             dout_valid,
  output logic             dout_bank,
  output logic             dout_first,
  output logic             dout_last,
  output logic             blk_done,
  output logic             err_pair_skew
);

  import filter_pkg::*;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_m1_q, len_m1_d;
  logic             skew_prev_q, skew_prev_d;
  logic             err_q, err_d;

  logic             active, bank, pair_e0, pair_e1, fire, mismatch;
  tag_t             tag_in, tag_out;
  logic             unused_ce;

  assign unused_ce = ce;

  always_comb begin
    active  = 1'b0;
    bank    = BANK_A;
    pair_e0 = 1'b1;
    pair_e1 = 1'b1;
    case (state_q)
      RD_A: begin
        active  = 1'b1;
        bank    = BANK_A;
        pair_e0 = fifo_empty1;
        pair_e1 = fifo_empty2;
      end
      RD_B: begin
        active  = 1'b1;
        bank    = BANK_B;
        pair_e0 = fifo_empty3;
        pair_e1 = fifo_empty4;
      end
      default: ;
    endcase
    fire     = active & enable & dst_rdy & ~pair_e0 & ~pair_e1;
    mismatch = active & enable & (pair_e0 ^ pair_e1);
  end

  assign fifo_rd1 = fire & (state_q == RD_A);
  assign fifo_rd2 = fire & (state_q == RD_A);
  assign fifo_rd3 = fire & (state_q == RD_B);
  assign fifo_rd4 = fire & (state_q == RD_B);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_m1_d    = len_m1_q;
    skew_prev_d = mismatch;
    err_d       = err_q | (mismatch & skew_prev_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          // packer_len = 0 wraps to an all-ones length, matching the writer
          len_m1_d = packer_len - 1'b1;
          err_d    = 1'b0;
          state_d  = RD_A;
        end
      end
      RD_A, RD_B: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (fire) begin
          if (cnt_q < len_m1_q) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = (state_q == RD_A) ? RD_B : RD_A;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_m1_q    <= '0;
      skew_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_m1_q    <= len_m1_d;
      skew_prev_q <= skew_prev_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    tag_in.valid = fire;
    tag_in.bank  = fire & bank;
    tag_in.first = fire & (cnt_q == '0);
    tag_in.last  = fire & (cnt_q == len_m1_q);
  end

  tag_delay_line #(
    .RD_LAT (RD_LAT),
    .DW     (4)
  ) u_tag_delay (
    .clk  (clk),
    .clr  (reset),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign dout_valid    = tag_out.valid;
  assign dout_bank     = tag_out.bank;
  assign dout_first    = tag_out.first;
  assign dout_last     = tag_out.last;
  assign blk_done      = tag_out.valid & tag_out.last;
  assign err_pair_skew = err_q;

endmodule
